// File: rtl/param_register_file.sv
// Multi-ported register file: three combinational reads, two falling-edge writes,
// optional write-to-read forwarding, and a hard-wired zero register.
module param_register_file #(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned ZERO_REG = 2**ADDR_W - 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic              Clk,
  input  logic              ResetL,
  input  logic [ADDR_W-1:0] RA,
  input  logic [ADDR_W-1:0] RB,
  input  logic [ADDR_W-1:0] RC,
  output logic [DATA_W-1:0] BusA,
  output logic [DATA_W-1:0] BusB,
  output logic [DATA_W-1:0] BusC,
  input  logic [ADDR_W-1:0] RW0,
  input  logic [ADDR_W-1:0] RW1,
  input  logic [DATA_W-1:0] BusW0,
  input  logic [DATA_W-1:0] BusW1,
  input  logic              RegWr0,
  input  logic              RegWr1,
  output logic              WrConflict,
  output logic [7:0]        ConflictCnt
);

  localparam int unsigned       Depth    = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZeroAddr = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] regsQ [Depth];
  logic              wrConflictQ;
  logic [7:0]        conflictCntQ;

  logic wrEn0;
  logic wrEn1;
  logic conflict;

  // Writes aimed at the zero register are dropped before they reach anything else.
  assign wrEn0    = RegWr0 && (RW0 != ZeroAddr);
  assign wrEn1    = RegWr1 && (RW1 != ZeroAddr);
  assign conflict = wrEn0 && wrEn1 && (RW0 == RW1);

  always_ff @(negedge Clk or negedge ResetL) begin
    if (!ResetL) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        regsQ[i] <= '0;
      end
    end else begin
      if (wrEn0) begin
        regsQ[RW0] <= BusW0;
      end
      // Port 1 is applied last so it wins a same-address conflict.
      if (wrEn1) begin
        regsQ[RW1] <= BusW1;
      end
    end
  end

  always_ff @(negedge Clk or negedge ResetL) begin
    if (!ResetL) begin
      wrConflictQ  <= 1'b0;
      conflictCntQ <= 8'd0;
    end else begin
      wrConflictQ <= conflict;
      if (conflict && (conflictCntQ != 8'hFF)) begin
        conflictCntQ <= conflictCntQ + 8'd1;
      end
    end
  end

  logic [ADDR_W-1:0] rdAddr [3];
  logic [DATA_W-1:0] rdData [3];

  assign rdAddr[0] = RA;
  assign rdAddr[1] = RB;
  assign rdAddr[2] = RC;

  always_comb begin
    for (int p = 0; p < 3; p++) begin
      rdData[p] = regsQ[rdAddr[p]];
      // Forwarding is suppressed during reset since those writes will be discarded.
      if ((BYPASS != 0) && ResetL) begin
        if (wrEn1 && (RW1 == rdAddr[p])) begin
          rdData[p] = BusW1;
        end else if (wrEn0 && (RW0 == rdAddr[p])) begin
          rdData[p] = BusW0;
        end
      end
      if (rdAddr[p] == ZeroAddr) begin
        rdData[p] = '0;
      end
    end
  end

  assign BusA        = rdData[0];
  assign BusB        = rdData[1];
  assign BusC        = rdData[2];
  assign WrConflict  = wrConflictQ;
  assign ConflictCnt = conflictCntQ;

endmodule

// File: tb/tb_param_register_file.sv
// Directed bench for param_register_file: a forwarding instance and a non-forwarding
// instance share all stimulus; expected values are hand-computed constants.
module tb_param_register_file;

  logic        Clk;
  logic        ResetL;
  logic [4:0]  RA, RB, RC, RW0, RW1;
  logic [63:0] BusW0, BusW1;
  logic        RegWr0, RegWr1;
  logic [63:0] BusA, BusB, BusC;
  logic [63:0] nbBusA, nbBusB, nbBusC;
  logic        WrConflict, nbWrConflict;
  logic [7:0]  ConflictCnt, nbConflictCnt;

  int total = 0;
  int bad   = 0;

  param_register_file #(.DATA_W(64), .ADDR_W(5), .BYPASS(1)) dut (
    .Clk(Clk), .ResetL(ResetL), .RA(RA), .RB(RB), .RC(RC),
    .BusA(BusA), .BusB(BusB), .BusC(BusC), .RW0(RW0), .RW1(RW1),
    .BusW0(BusW0), .BusW1(BusW1), .RegWr0(RegWr0), .RegWr1(RegWr1),
    .WrConflict(WrConflict), .ConflictCnt(ConflictCnt)
  );

  param_register_file #(.DATA_W(64), .ADDR_W(5), .BYPASS(0)) dutNb (
    .Clk(Clk), .ResetL(ResetL), .RA(RA), .RB(RB), .RC(RC),
    .BusA(nbBusA), .BusB(nbBusB), .BusC(nbBusC), .RW0(RW0), .RW1(RW1),
    .BusW0(BusW0), .BusW1(BusW1), .RegWr0(RegWr0), .RegWr1(RegWr1),
    .WrConflict(nbWrConflict), .ConflictCnt(nbConflictCnt)
  );

  initial Clk = 1'b1;
  always #5 Clk = ~Clk;

  typedef struct {
    logic        we0;
    logic [4:0]  rw0;
    logic [63:0] bw0;
    logic        we1;
    logic [4:0]  rw1;
    logic [63:0] bw1;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [63:0] expA;
    logic [63:0] expB;
    logic        expConf;
    logic [7:0]  expCnt;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Active edge is the falling one; land 1 time unit after it.
  task automatic tick();
    @(negedge Clk);
    #1;
  endtask

  task automatic idle();
    RegWr0 = 1'b0;
    RegWr1 = 1'b0;
  endtask

  initial begin
    vecs[0] = '{1'b1, 5'd10, 64'h1010, 1'b1, 5'd11, 64'h103000, 5'd10, 5'd11,
                64'd4112, 64'd1060864, 1'b0, 8'd0};
    vecs[1] = '{1'b1, 5'd13, 64'h1, 1'b1, 5'd13, 64'hABCD, 5'd13, 5'd10,
                64'd43981, 64'd4112, 1'b1, 8'd1};
    vecs[2] = '{1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0, 5'd13, 5'd11,
                64'd43981, 64'd1060864, 1'b0, 8'd1};
    vecs[3] = '{1'b0, 5'd0, 64'h0, 1'b1, 5'd5, 64'h55, 5'd5, 5'd4,
                64'h55, 64'd4, 1'b0, 8'd1};
    vecs[4] = '{1'b1, 5'd31, 64'h11, 1'b1, 5'd31, 64'h22, 5'd31, 5'd5,
                64'd0, 64'h55, 1'b0, 8'd1};
    vecs[5] = '{1'b1, 5'd20, 64'h7, 1'b1, 5'd20, 64'h9, 5'd20, 5'd13,
                64'h9, 64'd43981, 1'b1, 8'd2};

    ResetL = 1'b0;
    RA = '0; RB = '0; RC = '0; RW0 = '0; RW1 = '0;
    BusW0 = '0; BusW1 = '0;
    idle();
    #1;
    chk("reset BusA", BusA, 64'd0);
    chk("reset WrConflict", {63'd0, WrConflict}, 64'd0);
    chk("reset ConflictCnt", {56'd0, ConflictCnt}, 64'd0);
    #1 ResetL = 1'b1;

    // Fill every register i with i through port 0, then read back.
    for (int i = 0; i < 32; i++) begin
      RW0 = 5'(i); BusW0 = 64'(i); RegWr0 = 1'b1;
      tick();
    end
    idle();
    for (int i = 0; i < 32; i++) begin
      RA = 5'(i);
      #1;
      chk($sformatf("fill r%0d", i), BusA, (i < 31) ? 64'(i) : 64'd0);
    end

    // Zero register: write is ignored and never forwarded.
    RW0 = 5'd31; BusW0 = 64'hABCD; RegWr0 = 1'b1; RA = 5'd31;
    #1;
    chk("zero reg before edge", BusA, 64'd0);
    tick();
    idle();
    chk("zero reg after edge", BusA, 64'd0);
    chk("zero reg no conflict cnt", {56'd0, ConflictCnt}, 64'd0);

    for (int v = 0; v < 6; v++) begin
      RegWr0 = vecs[v].we0; RW0 = vecs[v].rw0; BusW0 = vecs[v].bw0;
      RegWr1 = vecs[v].we1; RW1 = vecs[v].rw1; BusW1 = vecs[v].bw1;
      tick();
      idle();
      RA = vecs[v].ra; RB = vecs[v].rb;
      #1;
      chk($sformatf("vec%0d BusA", v), BusA, vecs[v].expA);
      chk($sformatf("vec%0d BusB", v), BusB, vecs[v].expB);
      chk($sformatf("vec%0d nb BusA", v), nbBusA, vecs[v].expA);
      chk($sformatf("vec%0d WrConflict", v), {63'd0, WrConflict}, {63'd0, vecs[v].expConf});
      chk($sformatf("vec%0d ConflictCnt", v), {56'd0, ConflictCnt}, {56'd0, vecs[v].expCnt});
    end

    // Forwarding: port 0 alone, then both ports where port 1 must win.
    RA = 5'd14; RC = 5'd14; RW0 = 5'd14; BusW0 = 64'h9080009; RegWr0 = 1'b1;
    #1;
    chk("bypass port0 BusA", BusA, 64'h9080009);
    chk("bypass port0 BusC", BusC, 64'h9080009);
    chk("no-bypass old value", nbBusA, 64'd14);
    RW1 = 5'd14; BusW1 = 64'h77; RegWr1 = 1'b1;
    #1;
    chk("bypass both ports", BusA, 64'h77);
    chk("no-bypass both ports", nbBusA, 64'd14);
    tick();
    idle();
    chk("after bypass write", BusA, 64'h77);
    chk("after write no-bypass", nbBusA, 64'h77);
    chk("bypass conflict cnt", {56'd0, ConflictCnt}, 64'd3);

    // Saturation after 300 more conflicts.
    RW0 = 5'd1; RW1 = 5'd1; BusW0 = 64'h1; BusW1 = 64'h2;
    RegWr0 = 1'b1; RegWr1 = 1'b1;
    for (int i = 0; i < 300; i++) tick();
    idle();
    chk("saturated cnt", {56'd0, ConflictCnt}, 64'd255);
    chk("conflict pulse still high", {63'd0, WrConflict}, 64'd1);
    tick();
    chk("saturated cnt held", {56'd0, ConflictCnt}, 64'd255);
    chk("conflict pulse drops", {63'd0, WrConflict}, 64'd0);

    // Mid-cycle reset with a write pending; no clock edge involved.
    RW0 = 5'd2; BusW0 = 64'hFF; RegWr0 = 1'b1; RA = 5'd2; RB = 5'd14; RC = 5'd1;
    #2;
    ResetL = 1'b0;
    #1;
    chk("async rst BusA", BusA, 64'd0);
    chk("async rst BusB", BusB, 64'd0);
    chk("async rst BusC", BusC, 64'd0);
    chk("async rst cnt", {56'd0, ConflictCnt}, 64'd0);
    chk("async rst WrConflict", {63'd0, WrConflict}, 64'd0);
    // Hold reset across an edge while writing: must be ignored.
    RW0 = 5'd3; BusW0 = 64'h33;
    tick();
    idle();
    ResetL = 1'b1;
    RA = 5'd2; RB = 5'd3;
    #1;
    chk("discarded write r2", BusA, 64'd0);
    chk("ignored write r3", BusB, 64'd0);
    RW0 = 5'd3; BusW0 = 64'h33; RegWr0 = 1'b1;
    tick();
    idle();
    chk("resume write r3", BusB, 64'h33);
    chk("resume no-bypass r3", nbBusB, 64'h33);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, expected finish before 100000");
    $fatal(1);
  end

endmodule
